// File: rtl/mux4_to_1.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mux4_to_1
//  Brief    : Four-lane selector with combinational output and a registered,
//             enable-gated copy of the selected lane and its select.
//  Revision : 1.0 - initial release
// ============================================================================
module mux4_to_1 #(
  parameter int DATA_W = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            sel,
  input  logic [4*DATA_W-1:0]   in,
  input  logic                  en,
  output logic [DATA_W-1:0]     out,
  output logic [DATA_W-1:0]     out_q,
  output logic [1:0]            sel_q
);

  logic [DATA_W-1:0] w_out;
  logic [DATA_W-1:0] r_out_q;
  logic [1:0]        r_sel_q;

  // An unknown select must propagate X instead of silently picking lane 0.
  always_comb begin
    w_out = {DATA_W{1'bx}};
    case (sel)
      2'd0:    w_out = in[0*DATA_W +: DATA_W];
      2'd1:    w_out = in[1*DATA_W +: DATA_W];
      2'd2:    w_out = in[2*DATA_W +: DATA_W];
      2'd3:    w_out = in[3*DATA_W +: DATA_W];
      default: w_out = {DATA_W{1'bx}};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_q <= '0;
      r_sel_q <= 2'd0;
    end else if (en) begin
      r_out_q <= w_out;
      r_sel_q <= sel;
    end
  end

  assign out   = w_out;
  assign out_q = r_out_q;
  assign sel_q = r_sel_q;

endmodule
`default_nettype wire

// File: tb/tb_mux4_to_1.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_mux4_to_1
//  Brief    : Self-checking bench for mux4_to_1 with a behavioural lane model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mux4_to_1;

  localparam int c_DATA_W = 1;

  logic                  clk;
  logic                  rst;
  logic [1:0]            sel;
  logic [4*c_DATA_W-1:0] in;
  logic                  en;
  logic [c_DATA_W-1:0]   out;
  logic [c_DATA_W-1:0]   out_q;
  logic [1:0]            sel_q;

  logic r_clk_run;
  int   tests;
  int   fails;

  // Reference state for the registered stage.
  logic [c_DATA_W-1:0] m_out_q;
  logic [1:0]          m_sel_q;

  mux4_to_1 #(.DATA_W(c_DATA_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .sel   (sel),
    .in    (in),
    .en    (en),
    .out   (out),
    .out_q (out_q),
    .sel_q (sel_q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = r_clk_run ? ~clk : clk;
  end

  function automatic logic [c_DATA_W-1:0] lane_of(input logic [4*c_DATA_W-1:0] v,
                                                  input logic [1:0] s);
    logic [4*c_DATA_W-1:0] shifted;
    shifted = v >> (int'(s) * c_DATA_W);
    return shifted[c_DATA_W-1:0];
  endfunction

  task automatic test_comb_sweep();
    logic [3:0] exp_vals;
    exp_vals = 4'b1010;
    in = 4'b1010;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #10;
      tests++;
      if (out !== c_DATA_W'(exp_vals[s])) begin
        fails++;
        $display("FAIL comb_sweep sel=%0d out=%b expected=%b", s, out, exp_vals[s]);
      end
    end
  endtask

  task automatic test_walking_one();
    logic [c_DATA_W-1:0] exp;
    for (int b = 0; b < 4; b++) begin
      in = 4'(1 << b);
      for (int s = 0; s < 4; s++) begin
        sel = 2'(s);
        exp = (s == b) ? c_DATA_W'(1) : c_DATA_W'(0);
        #10;
        tests++;
        if (out !== exp) begin
          fails++;
          $display("FAIL walking_one in=%b sel=%0d out=%b expected=%b", in, s, out, exp);
        end
      end
    end
  endtask

  task automatic test_input_change();
    sel = 2'd2;
    in  = 4'b0000;
    #10;
    tests++;
    if (out !== 1'b0) begin
      fails++;
      $display("FAIL input_change_lo out=%b expected=0", out);
    end
    in = 4'b0100;
    #10;
    tests++;
    if (out !== 1'b1) begin
      fails++;
      $display("FAIL input_change_hi out=%b expected=1", out);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_out_q = '0;
    m_sel_q = 2'd0;
    tests++;
    if (out_q !== m_out_q || sel_q !== m_sel_q) begin
      fails++;
      $display("FAIL reset out_q=%b sel_q=%0d expected out_q=0 sel_q=0", out_q, sel_q);
    end
  endtask

  task automatic test_capture();
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;
    in  = 4'b1010;
    sel = 2'd3;
    @(posedge clk);
    #1;
    tests++;
    if (out_q !== 1'b1 || sel_q !== 2'd3) begin
      fails++;
      $display("FAIL capture out_q=%b sel_q=%0d expected out_q=1 sel_q=3", out_q, sel_q);
    end
  endtask

  task automatic test_hold();
    @(negedge clk);
    en  = 1'b0;
    sel = 2'd0;
    #1;
    tests++;
    if (out !== 1'b0) begin
      fails++;
      $display("FAIL hold_out out=%b expected=0", out);
    end
    for (int e = 0; e < 3; e++) begin
      @(posedge clk);
      #1;
      tests++;
      if (out_q !== 1'b1 || sel_q !== 2'd3) begin
        fails++;
        $display("FAIL hold edge=%0d out_q=%b sel_q=%0d expected out_q=1 sel_q=3",
                 e, out_q, sel_q);
      end
    end
  endtask

  task automatic test_reset_priority();
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b1;
    sel = 2'd1;
    in  = 4'b1010;
    #1;
    tests++;
    if (out !== 1'b1) begin
      fails++;
      $display("FAIL rst_prio_out_before out=%b expected=1", out);
    end
    @(posedge clk);
    #1;
    tests++;
    if (out_q !== 1'b0 || sel_q !== 2'd0 || out !== 1'b1) begin
      fails++;
      $display("FAIL rst_prio out_q=%b sel_q=%0d out=%b expected out_q=0 sel_q=0 out=1",
               out_q, sel_q, out);
    end
    m_out_q = '0;
    m_sel_q = 2'd0;
  endtask

  task automatic test_random();
    logic                  nrst;
    logic                  nen;
    logic [1:0]            nsel;
    logic [4*c_DATA_W-1:0] nin;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      nrst = ($urandom_range(0, 9) == 0);
      nen  = 1'($urandom);
      nsel = 2'($urandom);
      nin  = (4*c_DATA_W)'($urandom);
      rst = nrst; en = nen; sel = nsel; in = nin;
      #1;
      tests++;
      if (out !== lane_of(nin, nsel)) begin
        fails++;
        $display("FAIL rand_out i=%0d in=%b sel=%0d out=%b expected=%b",
                 i, nin, nsel, out, lane_of(nin, nsel));
      end
      @(posedge clk);
      if (nrst) begin
        m_out_q = '0;
        m_sel_q = 2'd0;
      end else if (nen) begin
        m_out_q = lane_of(nin, nsel);
        m_sel_q = nsel;
      end
      #1;
      // Disturb inputs between edges; the registered stage must not move.
      sel = 2'($urandom);
      in  = (4*c_DATA_W)'($urandom);
      #1;
      tests++;
      if (out_q !== m_out_q || sel_q !== m_sel_q) begin
        fails++;
        $display("FAIL rand_reg i=%0d out_q=%b sel_q=%0d expected out_q=%b sel_q=%0d",
                 i, out_q, sel_q, m_out_q, m_sel_q);
      end
    end
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    r_clk_run = 1'b0;
    rst       = 1'b0;
    en        = 1'b0;
    sel       = 2'd0;
    in        = '0;
    m_out_q   = '0;
    m_sel_q   = 2'd0;

    test_comb_sweep();
    test_walking_one();
    test_input_change();

    r_clk_run = 1'b1;
    test_reset();
    test_capture();
    test_hold();
    test_reset_priority();
    test_random();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
